// File: rtl/bin_to_bcd_pkg.sv
// ============================================================================
// Module : bin_to_bcd_pkg
// Brief  : Shared types and constants for the sequential binary-to-BCD converter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

    // Elaboration-time helpers for the parameter legality check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic longint unsigned max_unsigned(input int w);
        if (w >= 64) begin
            return {64{1'b1}};
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd_seq_add3.sv
// ============================================================================
// Module : bcd_add3_digit
// Brief  : Double-dabble digit correction: add 3 when the digit is 5 or more.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3_digit
    import bin_to_bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    assign digit_out = (digit_in >= ADD3_THRESHOLD) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module : bin_to_bcd_seq
// Brief  : Sequential shift-add-3 binary-to-BCD converter, one bit per clock,
//          valid/ready on both sides. Define BIN_TO_BCD_BLANK_EN to add the
//          registered leading-zero mask output out_blank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd
`ifdef BIN_TO_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     out_blank
`endif
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    generate
        if ((WIDTH < 1) || (pow10(DIGITS) <= max_unsigned(WIDTH))) begin : g_param_check
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH, or WIDTH < 1");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_next;
    logic [c_cnt_w-1:0]    r_count;
    logic [WIDTH-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [4*DIGITS-1:0]   w_bcd_adj;
    logic [4*DIGITS+WIDTH-1:0] w_shifted;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_add3
            bcd_add3_digit u_add3 (
                .digit_in  (r_bcd[4*d +: 4]),
                .digit_out (w_bcd_adj[4*d +: 4])
            );
        end
    endgenerate

    // Adjusted BCD and remaining binary bits shift left as one register.
    assign w_shifted = {w_bcd_adj, r_bin} << 1;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_count == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef BIN_TO_BCD_BLANK_EN
    localparam logic [DIGITS-1:0] c_blank_rst = ~DIGITS'(1);

    logic [DIGITS-1:0] w_blank;
    logic              w_high_zero;

    // Digit 0 is never blanked so a zero result still shows one digit.
    always_comb begin
        w_blank     = '0;
        w_high_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_high_zero = w_high_zero && (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i]  = w_high_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_blank <= c_blank_rst;
        end else if ((r_state == SHIFT) && (r_count == '0)) begin
            out_blank <= w_blank;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
            out_bcd <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin   <= in_bin;
                        r_bcd   <= '0;
                        r_count <= c_cnt_w'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (r_count != '0) begin
                        {r_bcd, r_bin} <= w_shifted;
                        r_count        <= r_count - c_cnt_w'(1);
                    end else begin
                        out_bcd <= r_bcd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
